// File: rtl/mos6502s_pkg.sv
// Shared types and constants for the 6502 instruction prefetch queue.
package mos6502s_pkg;

    typedef enum logic [1:0] {
        StOpc = 2'd0,
        StLo  = 2'd1,
        StHi  = 2'd2
    } asm_state_e;

    typedef logic [1:0] len_t;

    localparam len_t LenNone  = 2'd0;
    localparam len_t LenOne   = 2'd1;
    localparam len_t LenTwo   = 2'd2;
    localparam len_t LenThree = 2'd3;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [15:0] operand;
        len_t        len;
    } instr_t;

endpackage

// File: rtl/mos6502s_opcode_length.sv
// Combinational NMOS 6502 instruction length decode (documented opcodes; all others are 1 byte).
module mos6502s_opcode_length
    import mos6502s_pkg::*;
(
    input  logic [7:0] opcode,
    output len_t       len
);

    always_comb begin
        len = LenOne;
        case (opcode)
            // absolute, absolute indexed, indirect, JSR
            8'h20, 8'h4C, 8'h6C,
            8'h0D, 8'h0E, 8'h19, 8'h1D, 8'h1E,
            8'h2C, 8'h2D, 8'h2E, 8'h39, 8'h3D, 8'h3E,
            8'h4D, 8'h4E, 8'h59, 8'h5D, 8'h5E,
            8'h6D, 8'h6E, 8'h79, 8'h7D, 8'h7E,
            8'h8C, 8'h8D, 8'h8E, 8'h99, 8'h9D,
            8'hAC, 8'hAD, 8'hAE, 8'hB9, 8'hBC, 8'hBD, 8'hBE,
            8'hCC, 8'hCD, 8'hCE, 8'hD9, 8'hDD, 8'hDE,
            8'hEC, 8'hED, 8'hEE, 8'hF9, 8'hFD, 8'hFE: len = LenThree;
            // immediate, zero page (indexed/indirect), relative
            8'h09, 8'h29, 8'h49, 8'h69, 8'hA0, 8'hA2, 8'hA9, 8'hC0, 8'hC9, 8'hE0, 8'hE9,
            8'h05, 8'h06, 8'h24, 8'h25, 8'h26, 8'h45, 8'h46, 8'h65, 8'h66,
            8'h84, 8'h85, 8'h86, 8'hA4, 8'hA5, 8'hA6, 8'hC4, 8'hC5, 8'hC6,
            8'hE4, 8'hE5, 8'hE6,
            8'h15, 8'h16, 8'h35, 8'h36, 8'h55, 8'h56, 8'h75, 8'h76,
            8'h94, 8'h95, 8'h96, 8'hB4, 8'hB5, 8'hB6, 8'hD5, 8'hD6, 8'hF5, 8'hF6,
            8'h01, 8'h21, 8'h41, 8'h61, 8'h81, 8'hA1, 8'hC1, 8'hE1,
            8'h11, 8'h31, 8'h51, 8'h71, 8'h91, 8'hB1, 8'hD1, 8'hF1,
            8'h10, 8'h30, 8'h50, 8'h70, 8'h90, 8'hB0, 8'hD0, 8'hF0: len = LenTwo;
            default: len = LenOne;
        endcase
    end

endmodule

// File: rtl/mos6502s_instruction_prefetch.sv
// Assembles fetched bytes into whole 6502 instructions and queues them in a small FIFO.
// Optional macro MOS6502S_PREFETCH_PC_EN adds fetch-PC tracking and a per-entry opcode PC.
module mos6502s_instruction_prefetch
    import mos6502s_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0]             out_opcode,
    output logic [15:0]            out_operand,
    output logic [1:0]             out_len,
`ifdef MOS6502S_PREFETCH_PC_EN
    input  logic                   pc_load,
    input  logic [15:0]            pc_value,
    output logic [15:0]            out_pc,
`endif
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] Full = CntW'(DEPTH);

    asm_state_e      state_q;
    logic [7:0]      opc_q, lo_q;
    len_t            len_q;
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] cnt_q;
    instr_t          mem [DEPTH];

    len_t   dec_len;
    logic   clear, accept, push, pop, empty;
    instr_t push_entry, head;

    mos6502s_opcode_length u_len (
        .opcode (in_data),
        .len    (dec_len)
    );

`ifdef MOS6502S_PREFETCH_PC_EN
    logic [15:0] pc_q, opc_pc_q, push_pc;
    logic [15:0] mem_pc [DEPTH];
    // A PC load invalidates everything fetched from the old address.
    assign clear   = flush | pc_load;
    assign push_pc = (state_q == StOpc) ? pc_q : opc_pc_q;
    assign out_pc  = empty ? 16'h0000 : mem_pc[rd_ptr_q];
`else
    assign clear = flush;
`endif

    assign empty    = (cnt_q == '0);
    assign in_ready = (cnt_q != Full) && !clear;
    assign accept   = in_valid && in_ready;
    assign pop      = !empty && out_ready;
    assign head     = mem[rd_ptr_q];

    always_comb begin
        push       = 1'b0;
        push_entry = '0;
        if (accept) begin
            case (state_q)
                StOpc: begin
                    push       = (dec_len == LenOne);
                    push_entry = '{opcode: in_data, operand: 16'h0000, len: LenOne};
                end
                StLo: begin
                    push       = (len_q == LenTwo);
                    push_entry = '{opcode: opc_q, operand: {8'h00, in_data}, len: LenTwo};
                end
                StHi: begin
                    push       = 1'b1;
                    push_entry = '{opcode: opc_q, operand: {in_data, lo_q}, len: LenThree};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StOpc;
            opc_q    <= '0;
            lo_q     <= '0;
            len_q    <= LenNone;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
`ifdef MOS6502S_PREFETCH_PC_EN
            pc_q     <= '0;
            opc_pc_q <= '0;
`endif
        end else if (clear) begin
            state_q  <= StOpc;
            opc_q    <= '0;
            lo_q     <= '0;
            len_q    <= LenNone;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
`ifdef MOS6502S_PREFETCH_PC_EN
            if (pc_load) pc_q <= pc_value;
`endif
        end else begin
            if (accept) begin
`ifdef MOS6502S_PREFETCH_PC_EN
                pc_q <= pc_q + 16'd1;
`endif
                case (state_q)
                    StOpc: begin
                        if (dec_len != LenOne) begin
                            opc_q   <= in_data;
                            len_q   <= dec_len;
                            state_q <= StLo;
`ifdef MOS6502S_PREFETCH_PC_EN
                            opc_pc_q <= pc_q;
`endif
                        end
                    end
                    StLo: begin
                        lo_q    <= in_data;
                        state_q <= (len_q == LenThree) ? StHi : StOpc;
                    end
                    default: state_q <= StOpc;
                endcase
            end
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            cnt_q <= cnt_q + CntW'(push) - CntW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst && !clear && push) begin
            mem[wr_ptr_q] <= push_entry;
`ifdef MOS6502S_PREFETCH_PC_EN
            mem_pc[wr_ptr_q] <= push_pc;
`endif
        end
    end

    assign out_valid   = !empty;
    assign out_opcode  = empty ? 8'h00 : head.opcode;
    assign out_operand = empty ? 16'h0000 : head.operand;
    assign out_len     = empty ? LenNone : head.len;
    assign count       = cnt_q;

endmodule

// File: tb/tb_mos6502s_instruction_prefetch.sv
// Directed scenarios plus a randomized run checked against a queue-based instruction model.
module tb_mos6502s_instruction_prefetch;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid;
    logic [7:0]  out_opcode;
    logic [15:0] out_operand;
    logic [1:0]  out_len;
    logic [2:0]  count;
`ifdef MOS6502S_PREFETCH_PC_EN
    logic        pc_load = 1'b0;
    logic [15:0] pc_value = 16'h0000;
    logic [15:0] out_pc;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mos6502s_instruction_prefetch #(.DEPTH(DEPTH), .DATA_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_opcode  (out_opcode),
        .out_operand (out_operand),
        .out_len     (out_len),
`ifdef MOS6502S_PREFETCH_PC_EN
        .pc_load     (pc_load),
        .pc_value    (pc_value),
        .out_pc      (out_pc),
`endif
        .count       (count)
    );

    // Non-uniform opcodes of the cc=00/cc=10 columns, grouped by total length.
    logic [7:0] misc_three [$] = '{8'h20, 8'h2C, 8'h4C, 8'h6C, 8'h8C, 8'hAC, 8'hBC, 8'hCC, 8'hEC,
                                   8'h0E, 8'h2E, 8'h4E, 8'h6E, 8'h8E, 8'hAE, 8'hCE, 8'hEE,
                                   8'h1E, 8'h3E, 8'h5E, 8'h7E, 8'hBE, 8'hDE, 8'hFE};
    logic [7:0] misc_two [$] = '{8'hA0, 8'hC0, 8'hE0, 8'hA2, 8'h24, 8'h84, 8'hA4, 8'hC4, 8'hE4,
                                 8'h94, 8'hB4, 8'h06, 8'h26, 8'h46, 8'h66, 8'h86, 8'hA6, 8'hC6,
                                 8'hE6, 8'h16, 8'h36, 8'h56, 8'h76, 8'hD6, 8'hF6, 8'h96, 8'hB6};

    function automatic int ref_len(input logic [7:0] op);
        int mode;
        mode = int'(op[4:2]);
        if (op[1:0] == 2'b01) begin
            if (mode == 3 || mode >= 6) return 3;
            return (op == 8'h89) ? 1 : 2;
        end
        if (op[4:0] == 5'h10) return 2;
        foreach (misc_three[i]) if (misc_three[i] == op) return 3;
        foreach (misc_two[i]) if (misc_two[i] == op) return 2;
        return 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data = b;
        step();
        in_valid = 1'b0;
    endtask

    task automatic check_head(input string tag, input logic [7:0] op, input logic [15:0] opr,
                              input logic [1:0] len);
        check({tag, " opcode"}, 32'(out_opcode), 32'(op));
        check({tag, " operand"}, 32'(out_operand), 32'(opr));
        check({tag, " len"}, 32'(out_len), 32'(len));
    endtask

    typedef struct {
        logic [7:0]  opc;
        logic [15:0] opr;
        int          len;
    } ins_t;

    ins_t       q [$];
    logic [7:0] part [$];

    initial begin
        ins_t        e;
        logic        exp_ir, exp_ov, acc, pp;
        logic [7:0]  exp_op;
        logic [15:0] exp_opr;
        int          exp_len;

        do_reset();
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset count", 32'(count), 32'd0);
        check_head("reset", 8'h00, 16'h0000, 2'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);

        // A9 42: two-byte immediate
        push_byte(8'hA9);
        check("a9 partial out_valid", 32'(out_valid), 32'd0);
        push_byte(8'h42);
        check("a9 out_valid", 32'(out_valid), 32'd1);
        check_head("a9", 8'hA9, 16'h0042, 2'd2);

        // AD 34 12 EA with consumer stalled
        do_reset();
        push_byte(8'hAD);
        push_byte(8'h34);
        push_byte(8'h12);
        push_byte(8'hEA);
        check("ad count", 32'(count), 32'd2);
        check_head("ad head", 8'hAD, 16'h1234, 2'd3);
        step();
        check_head("ad held", 8'hAD, 16'h1234, 2'd3);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("ad pop count", 32'(count), 32'd1);
        check_head("ea head", 8'hEA, 16'h0000, 2'd1);

        // Fill to DEPTH, then hold the extra byte until a pop frees a slot
        do_reset();
        for (int i = 0; i < 4; i++) push_byte(8'hEA);
        check("full count", 32'(count), 32'd4);
        check("full in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_data = 8'hEA;
        step();
        check("full held count", 32'(count), 32'd4);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("after pop count", 32'(count), 32'd3);
        check("after pop in_ready", 32'(in_ready), 32'd1);
        step();
        check("refill count", 32'(count), 32'd4);
        step();
        in_valid = 1'b0;
        check("sixth held count", 32'(count), 32'd4);

        // Flush drops a partial AD 34
        do_reset();
        push_byte(8'hAD);
        push_byte(8'h34);
        flush = 1'b1;
        #1;
        check("flush in_ready", 32'(in_ready), 32'd0);
        step();
        flush = 1'b0;
        check("flush count", 32'(count), 32'd0);
        push_byte(8'hEA);
        check("post flush count", 32'(count), 32'd1);
        check_head("post flush", 8'hEA, 16'h0000, 2'd1);

        // Reset while waiting for the high operand byte
        do_reset();
        push_byte(8'hEA);
        push_byte(8'hAD);
        push_byte(8'h34);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("midhi out_valid", 32'(out_valid), 32'd0);
        check("midhi count", 32'(count), 32'd0);
        check_head("midhi", 8'h00, 16'h0000, 2'd0);
        push_byte(8'hEA);
        check_head("midhi opc state", 8'hEA, 16'h0000, 2'd1);

`ifdef MOS6502S_PREFETCH_PC_EN
        do_reset();
        pc_load = 1'b1;
        pc_value = 16'hC000;
        step();
        pc_load = 1'b0;
        push_byte(8'hA9);
        push_byte(8'h01);
        push_byte(8'hEA);
        check("pc first", 32'(out_pc), 32'hC000);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("pc second", 32'(out_pc), 32'hC002);
`endif

        // Randomized run against the instruction-queue model
        do_reset();
        q.delete();
        part.delete();
        for (int i = 0; i < 800; i++) begin
            flush = ($urandom_range(0, 39) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            in_data = 8'($urandom);
            out_ready = (i < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            #1;
            exp_ir = (q.size() != DEPTH) && !flush;
            exp_ov = (q.size() != 0);
            exp_op = exp_ov ? q[0].opc : 8'h00;
            exp_opr = exp_ov ? q[0].opr : 16'h0000;
            exp_len = exp_ov ? q[0].len : 0;
            check($sformatf("rnd%0d count", i), 32'(count), 32'(q.size()));
            check($sformatf("rnd%0d in_ready", i), 32'(in_ready), 32'(exp_ir));
            check($sformatf("rnd%0d out_valid", i), 32'(out_valid), 32'(exp_ov));
            check_head($sformatf("rnd%0d", i), exp_op, exp_opr, 2'(exp_len));
            if (flush) begin
                q.delete();
                part.delete();
            end else begin
                acc = in_valid && exp_ir;
                pp = exp_ov && out_ready;
                if (pp) void'(q.pop_front());
                if (acc) begin
                    part.push_back(in_data);
                    if (part.size() == ref_len(part[0])) begin
                        e.opc = part[0];
                        e.len = part.size();
                        e.opr = (e.len == 3) ? {part[2], part[1]} :
                                (e.len == 2) ? {8'h00, part[1]} : 16'h0000;
                        q.push_back(e);
                        part.delete();
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mos6502s_instruction_prefetch.md
MOS6502S_INSTRUCTION_PREFETCH -- requirements
Module: mos6502s_instruction_prefetch

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of assembled-instruction FIFO entries (a power of two, 2..16).
REQ-002 SHALL have parameter DATA_W, default 8, meaning the fetch byte width (fixed at 8; other values are unsupported).
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  meaning reset, synchronous and active-low.
REQ-005 SHALL have port flush  input  1  meaning discard all queued and partial instructions.
REQ-006 SHALL have port in_valid  input  1  meaning a fetched byte is present on in_data.
REQ-007 SHALL have port in_data  input  8  meaning the fetched byte.
REQ-008 SHALL have port in_ready  output  1  meaning the block accepts a byte this cycle.
REQ-009 SHALL have port out_valid  output  1  meaning the FIFO head instruction is valid.
REQ-010 SHALL have port out_ready  input  1  meaning the consumer takes the head instruction.
REQ-011 SHALL have port out_opcode  output  8  meaning the head opcode.
REQ-012 SHALL have port out_operand  output  16  meaning the head operand as {hi,lo}, with unused bytes zero.
REQ-013 SHALL have port out_len  output  2  meaning the head instruction length in bytes (1..3).
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  meaning the number of occupied FIFO entries.

Function
REQ-015 SHALL accept a byte when in_valid && in_ready, and SHALL drive in_ready = (count != DEPTH) && !flush.
REQ-016 SHALL run assembler FSM states: OPC (expect opcode), LO (expect operand low), HI (expect operand high).
REQ-017 SHALL, in OPC on an accepted byte, latch the opcode and the decoded length L: L=1 pushes the instruction and stays in OPC; L>=2 goes to LO.
REQ-018 SHALL, in LO on an accepted byte, latch the low operand: L=2 pushes and goes to OPC; L=3 goes to HI.
REQ-019 SHALL, in HI on an accepted byte, push {opcode, hi, lo, L} and go to OPC.
REQ-020 SHALL decode length per documented NMOS 6502 addressing modes (implied/accumulator=1; immediate/zp/zp,X/zp,Y/(zp,X)/(zp),Y/relative=2; abs/abs,X/abs,Y/(abs)=3), with BRK=1 and undocumented opcodes=1.
REQ-021 SHALL give latency: out_valid rises the cycle after the last byte of an instruction is accepted into an empty FIFO.
REQ-022 SHALL pop the head when out_valid && out_ready; simultaneous push and pop SHALL leave count unchanged.
REQ-023 SHALL wrap the FIFO read/write pointers modulo DEPTH; when full, in_ready=0 and no byte is accepted (mid-instruction stalls hold FSM state).
REQ-024 SHALL hold out_* stable while out_valid && !out_ready.
REQ-025 SHALL drive outputs to zero when the FIFO is empty.
REQ-026 SHALL, on flush, set count=0, FSM=OPC and discard the partial instruction in the same edge; flush overrides push and pop.

Reset
REQ-027 SHALL, on rst==0 at a clock edge: FSM=OPC, pointers=0, count=0, out_valid=0, out_opcode=0x00, out_operand=0x0000, out_len=0, latched opcode/operands=0.
REQ-028 SHALL give reset priority over flush and over all handshakes, including mid-instruction.

Configuration
REQ-029 SHALL use macro MOS6502S_PREFETCH_PC_EN.
REQ-030 SHALL, when MOS6502S_PREFETCH_PC_EN is defined, add inputs pc_load (1) and pc_value (16) and output out_pc (16): pc_load sets the internal fetch PC; each accepted byte increments it; each entry stores the PC of its opcode byte; pc_load acts like flush for queued data.
REQ-031 SHALL, when MOS6502S_PREFETCH_PC_EN is undefined, have none of these ports or storage.

Structure
REQ-032 SHALL place FSM state encoding, the length type, and the opcode length table constants in shared package mos6502s_pkg.
REQ-033 SHALL implement length decode as combinational sub-module mos6502s_opcode_length (opcode in, length out).

Verification
REQ-034 SHALL cover: bytes A9,42 -> one entry: opcode=A9, operand=0x0042, len=2, out_valid one cycle after 0x42 is accepted.
REQ-035 SHALL cover: bytes AD,34,12,EA -> entries {AD,0x1234,3} then {EA,0x0000,1}, count=2 with out_ready=0.
REQ-036 SHALL cover: DEPTH=4, six EA bytes with out_ready=0 -> count=4, in_ready=0, 5th byte held, and 5th accepted after one pop.
REQ-037 SHALL cover: AD,34 then flush, then EA -> count=1, head={EA,0x0000,1} (partial discarded).
REQ-038 SHALL cover: rst=0 mid-HI state -> all outputs zero next cycle, FSM=OPC.
REQ-039 SHALL cover (PC_EN): pc_load 0xC000, bytes A9,01,EA -> out_pc 0xC000 then 0xC002.
